sap_control_sequencer: RTL



---
 rtl/sap_control_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - six-phase ring sequencer and control-word decoder
// One-hot T1..T6 ring plus a sticky HALT state; control word is decoded from state and opcode.
module sap_control_sequencer #(
  parameter logic [3:0] LDA_OP = 4'h0,
  parameter logic [3:0] ADD_OP = 4'h1,
  parameter logic [3:0] SUB_OP = 4'h2,
  parameter logic [3:0] OUT_OP = 4'hE,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] t_state
);

  typedef enum logic [6:0] {
    S_T1   = 7'b0000001,
    S_T2   = 7'b0000010,
    S_T3   = 7'b0000100,
    S_T4   = 7'b0001000,
    S_T5   = 7'b0010000,
    S_T6   = 7'b0100000,
    S_HALT = 7'b1000000
  } state_t;

  state_t state;
  state_t state_next;

  logic is_mem_op;

  assign is_mem_op = (opcode == LDA_OP) || (opcode == ADD_OP) || (opcode == SUB_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_T1;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cp         = 1'b0;
    ep         = 1'b0;
    lm         = 1'b0;
    ce         = 1'b0;
    li         = 1'b0;
    ei         = 1'b0;
    la         = 1'b0;
    ea         = 1'b0;
    su         = 1'b0;
    eu         = 1'b0;
    lb         = 1'b0;
    lo         = 1'b0;
    hlt        = 1'b0;
    t_state    = state[5:0];

    case (state)
      S_T1: begin
        ep         = 1'b1;
        lm         = 1'b1;
        state_next = S_T2;
      end
      S_T2: begin
        cp         = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        ce         = 1'b1;
        li         = 1'b1;
        state_next = S_T4;
      end
      S_T4: begin
        if (is_mem_op) begin
          ei = 1'b1;
          lm = 1'b1;
        end else if (opcode == OUT_OP) begin
          ea = 1'b1;
          lo = 1'b1;
        end
        state_next = (opcode == HLT_OP) ? S_HALT : S_T5;
      end
      S_T5: begin
        if (opcode == LDA_OP) begin
          ce = 1'b1;
          la = 1'b1;
        end else if ((opcode == ADD_OP) || (opcode == SUB_OP)) begin
          ce = 1'b1;
          lb = 1'b1;
        end
        state_next = S_T6;
      end
      S_T6: begin
        if ((opcode == ADD_OP) || (opcode == SUB_OP)) begin
          eu = 1'b1;
          la = 1'b1;
          su = (opcode == SUB_OP);
        end
        state_next = S_T1;
      end
      S_HALT: begin
        hlt        = 1'b1;
        state_next = S_HALT;
      end
      default: begin
        state_next = S_T1;
      end
    endcase

    // Reset aborts immediately: the control word must not leak a pulse in the reset cycle.
    if (rst) begin
      cp      = 1'b0;
      ep      = 1'b0;
      lm      = 1'b0;
      ce      = 1'b0;
      li      = 1'b0;
      ei      = 1'b0;
      la      = 1'b0;
      ea      = 1'b0;
      su      = 1'b0;
      eu      = 1'b0;
      lb      = 1'b0;
      lo      = 1'b0;
      hlt     = 1'b0;
      t_state = 6'b000001;
    end
  end

endmodule
